// File: rtl/req_encoder4to2.sv
// req_encoder4to2: sequential priority encoder.
// Latches rising edges on req_in into a pending set and presents them one at
// a time as binary codes over a valid/ready handshake. The lowest index has
// the highest priority. A presented code is never preempted.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   capture enable for new request edges
//   req_in    in   [N]  request lines, rising edge raises a request
//   code      out  [W]  index of the presented request (valid while valid=1)
//   valid     out  a code is presented
//   ready     in   consumer accepts code when valid & ready at an edge
//   pending   out  [N]  latched, not-yet-accepted requests
//   overflow  out  one-cycle pulse when an edge merged into a pending bit
module req_encoder4to2 #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req_in,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_code;
    logic [W-1:0]   w_code_next;
    logic [N-1:0]   r_req_q;
    logic [N-1:0]   r_pending;
    logic           r_overflow;

    logic [N-1:0]   w_set;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_rem;
    logic [N-1:0]   w_pending_next;
    logic           w_overflow_next;
    logic           w_handshake;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [W-1:0] f_lowest(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    // Edge capture, clear of the accepted bit, merge detection.
    always_comb begin
        w_handshake     = (r_state == ST_PRESENT) && ready;
        w_set           = en ? (req_in & ~r_req_q) : '0;
        w_clr           = w_handshake ? (N'(1) << r_code) : '0;
        w_rem           = r_pending & ~w_clr;
        // A new edge on the bit being cleared keeps it pending (set wins).
        w_pending_next  = w_rem | w_set;
        w_overflow_next = |(w_set & w_rem);
    end

    // Next-state and code selection. Bits captured this cycle are not in
    // r_pending yet, so they are only considered from the next cycle on.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != '0) begin
                    w_state_next = ST_PRESENT;
                    w_code_next  = f_lowest(r_pending);
                end
            end
            ST_PRESENT: begin
                if (w_handshake) begin
                    if (w_rem != '0) begin
                        w_code_next = f_lowest(w_rem);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
        end
    end

    // Edge detector, pending set and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_req_q    <= req_in;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign code     = r_code;
    assign valid    = (r_state == ST_PRESENT);
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_req_encoder4to2.sv
module tb_req_encoder4to2;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req_in;
    logic [W-1:0] code;
    logic         valid;
    logic         ready;
    logic [N-1:0] pending;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_encoder4to2 #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req_in   (req_in),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .overflow (overflow)
    );

    // Reference model: request set as a bit array, presentation as a
    // (valid, index) pair, advanced once per clock edge.
    bit m_prev [N];
    bit m_pend [N];
    bit m_valid;
    int m_code;
    bit m_ovf;

    function automatic void model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_code  = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic int model_pending();
        int s = 0;
        for (int i = 0; i < int'(N); i++) if (m_pend[i]) s += (1 << i);
        return s;
    endfunction

    function automatic void model_edge();
        bit hs;
        bit nxt [N];
        bit ovf;
        int first;
        hs    = m_valid && ready;
        ovf   = 1'b0;
        first = -1;
        for (int i = 0; i < int'(N); i++) begin
            bit cap;
            bit clr;
            cap = en && req_in[i] && !m_prev[i];
            clr = hs && (i == m_code);
            if (cap && m_pend[i] && !clr) ovf = 1'b1;
            nxt[i] = (m_pend[i] && !clr) || cap;
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (m_pend[i] && !(hs && i == m_code)) first = i;
        end
        if (!m_valid) begin
            if (first >= 0) begin
                m_valid = 1'b1;
                m_code  = first;
            end
        end else if (hs) begin
            if (first >= 0) m_code = first;
            else            m_valid = 1'b0;
        end
        for (int i = 0; i < int'(N); i++) begin
            m_prev[i] = req_in[i];
            m_pend[i] = nxt[i];
        end
        m_ovf = ovf;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, take one edge, sample 1ns after it.
    task automatic step(input bit e, input logic [N-1:0] r, input bit rd);
        en     = e;
        req_in = r;
        ready  = rd;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    typedef struct {
        bit           en;
        logic [N-1:0] req;
        bit           rdy;
        bit           v;
        int           code;
        logic [N-1:0] pend;
        bit           ovf;
    } vec_t;

    vec_t tbl [$];

    initial begin
        // en, req, rdy -> valid, code, pending, overflow after the edge
        // single request
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0100, 1'b1, 1'b0, 0, 4'b0100, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b1, 2, 4'b0100, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        // priority with stall, then back-to-back 0,1,3
        tbl.push_back(vec_t'{1'b1, 4'b1011, 1'b0, 1'b0, 0, 4'b1011, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b1, 0, 4'b1011, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b1, 0, 4'b1011, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b1, 1, 4'b1010, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b1, 3, 4'b1000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        // no preemption
        tbl.push_back(vec_t'{1'b1, 4'b1000, 1'b0, 1'b0, 0, 4'b1000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b1, 3, 4'b1000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0001, 1'b0, 1'b1, 3, 4'b1001, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b1, 3, 4'b1001, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b1, 0, 4'b0001, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        // overflow, then set-wins on the accepted bit
        tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 1'b0, 0, 4'b0010, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b1, 1, 4'b0010, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b0, 1'b1, 1, 4'b0010, 1'b1});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b1, 1, 4'b0010, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0010, 1'b1, 1'b0, 0, 4'b0010, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b0, 1'b1, 1, 4'b0010, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        // enable gating, held input across enable rise, then a real capture
        tbl.push_back(vec_t'{1'b0, 4'b1111, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 4'b0100, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0100, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0100, 1'b1, 1'b0, 0, 4'b0100, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b1, 2, 4'b0100, 1'b0});
        tbl.push_back(vec_t'{1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1'b0});

        // reset
        rst_n  = 1'b0;
        en     = 1'b0;
        req_in = '0;
        ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid",    int'(valid),    0);
        check("reset_code",     int'(code),     0);
        check("reset_pending",  int'(pending),  0);
        check("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;

        // directed table
        foreach (tbl[k]) begin
            step(tbl[k].en, tbl[k].req, tbl[k].rdy);
            check($sformatf("tbl%0d_valid", k),    int'(valid),    int'(tbl[k].v));
            check($sformatf("tbl%0d_pending", k),  int'(pending),  int'(tbl[k].pend));
            check($sformatf("tbl%0d_overflow", k), int'(overflow), int'(tbl[k].ovf));
            if (tbl[k].v) check($sformatf("tbl%0d_code", k), int'(code), tbl[k].code);
        end

        // async reset mid-operation with pending=1010
        step(1'b1, 4'b1010, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        check("pre_rst_pending", int'(pending), 'b1010);
        check("pre_rst_valid",   int'(valid),   1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",    int'(valid),    0);
        check("async_rst_code",     int'(code),     0);
        check("async_rst_pending",  int'(pending),  0);
        check("async_rst_overflow", int'(overflow), 0);
        model_reset();

        // request held high through reset release gives one edge
        en     = 1'b1;
        req_in = 4'b0001;
        ready  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'b0001, 1'b0);
        check("held_rst_pending", int'(pending), 'b0001);
        step(1'b1, 4'b0001, 1'b1);
        check("held_rst_valid", int'(valid), 1);
        check("held_rst_code",  int'(code),  0);
        step(1'b1, 4'b0001, 1'b1);
        check("held_rst_done_valid",   int'(valid),   0);
        check("held_rst_done_pending", int'(pending), 0);

        // randomized run against the reference model
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] r;
            r = N'($urandom) & N'($urandom);
            step(($urandom_range(0, 7) != 0), r, ($urandom_range(0, 2) != 0));
            check($sformatf("rnd%0d_valid", c),    int'(valid),    int'(m_valid));
            check($sformatf("rnd%0d_pending", c),  int'(pending),  model_pending());
            check($sformatf("rnd%0d_overflow", c), int'(overflow), int'(m_ovf));
            if (m_valid) check($sformatf("rnd%0d_code", c), int'(code), m_code);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
